// File: rtl/if_fetch.sv
// Instruction fetch unit: owns the PC, issues imem word requests and fills the IF/ID register.
// Define IF_FETCH_ALIGN_CHK_EN to add the if_misalign output for unaligned redirect targets.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic [31:0] if_instrn,
  output logic [31:0] if_pc_addrout,
  output logic [31:0] if_pcp4,
  output logic        if_valid
`ifdef IF_FETCH_ALIGN_CHK_EN
  ,
  output logic        if_misalign
`endif
);

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] ST_FETCH   = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  logic [1:0]      r_state,     w_state_nxt;
  logic [XLEN-1:0] r_pc,        w_pc_nxt;
  logic [XLEN-1:0] r_disc_addr, w_disc_addr_nxt;
  logic [XLEN-1:0] r_skid_data, w_skid_data_nxt;
  logic [XLEN-1:0] r_skid_pc,   w_skid_pc_nxt;
  logic            r_skid_vld,  w_skid_vld_nxt;
  logic [XLEN-1:0] r_instrn,    w_instrn_nxt;
  logic [XLEN-1:0] r_pc_out,    w_pc_out_nxt;
  logic [XLEN-1:0] r_pcp4,      w_pcp4_nxt;
  logic            r_valid,     w_valid_nxt;

  logic            w_fetch_ack;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_pc_inc;

  assign w_fetch_ack = (r_state == ST_FETCH) && imem_ack;
  assign w_target    = {redirect_addr[XLEN-1:2], 2'b00};
  assign w_pc_inc    = r_pc + XLEN'(4);

  // Next-state and datapath decode; redirect outranks stall and any ack.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_disc_addr_nxt = r_disc_addr;
    w_skid_data_nxt = r_skid_data;
    w_skid_pc_nxt   = r_skid_pc;
    w_skid_vld_nxt  = r_skid_vld;
    w_instrn_nxt    = r_instrn;
    w_pc_out_nxt    = r_pc_out;
    w_pcp4_nxt      = r_pcp4;
    w_valid_nxt     = r_valid;

    if (redirect) begin
      w_valid_nxt    = 1'b0;
      w_skid_vld_nxt = 1'b0;
      w_pc_nxt       = w_target;
      case (r_state)
        ST_FETCH: begin
          if (!imem_ack) begin
            w_disc_addr_nxt = r_pc;
            w_state_nxt     = ST_DISCARD;
          end
        end
        ST_HOLD:    w_state_nxt = ST_FETCH;
        ST_DISCARD: if (imem_ack) w_state_nxt = ST_FETCH;
        default:    w_state_nxt = ST_FETCH;
      endcase
    end else begin
      if (!stall) begin
        if (r_skid_vld) begin
          w_instrn_nxt   = r_skid_data;
          w_pc_out_nxt   = r_skid_pc;
          w_pcp4_nxt     = r_skid_pc + XLEN'(4);
          w_valid_nxt    = 1'b1;
          w_skid_vld_nxt = 1'b0;
        end else if (w_fetch_ack) begin
          w_instrn_nxt = imem_rdata;
          w_pc_out_nxt = r_pc;
          w_pcp4_nxt   = w_pc_inc;
          w_valid_nxt  = 1'b1;
        end else begin
          w_valid_nxt  = 1'b0;
        end
      end else if (w_fetch_ack) begin
        // A held valid instruction must survive; park the response instead.
        if (r_valid) begin
          w_skid_data_nxt = imem_rdata;
          w_skid_pc_nxt   = r_pc;
          w_skid_vld_nxt  = 1'b1;
        end else begin
          w_instrn_nxt = imem_rdata;
          w_pc_out_nxt = r_pc;
          w_pcp4_nxt   = w_pc_inc;
          w_valid_nxt  = 1'b1;
        end
      end

      case (r_state)
        ST_FETCH: begin
          if (imem_ack) begin
            w_pc_nxt = w_pc_inc;
            if (stall && r_valid) w_state_nxt = ST_HOLD;
          end
        end
        ST_HOLD:    if (!stall) w_state_nxt = ST_FETCH;
        ST_DISCARD: if (imem_ack) w_state_nxt = ST_FETCH;
        default:    w_state_nxt = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_FETCH;
      r_pc        <= RESET_PC;
      r_disc_addr <= '0;
      r_skid_data <= '0;
      r_skid_pc   <= '0;
      r_skid_vld  <= 1'b0;
      r_instrn    <= '0;
      r_pc_out    <= '0;
      r_pcp4      <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_disc_addr <= w_disc_addr_nxt;
      r_skid_data <= w_skid_data_nxt;
      r_skid_pc   <= w_skid_pc_nxt;
      r_skid_vld  <= w_skid_vld_nxt;
      r_instrn    <= w_instrn_nxt;
      r_pc_out    <= w_pc_out_nxt;
      r_pcp4      <= w_pcp4_nxt;
      r_valid     <= w_valid_nxt;
    end
  end

  assign imem_req      = !rst && (r_state != ST_HOLD);
  assign imem_addr     = (r_state == ST_DISCARD) ? r_disc_addr : r_pc;
  assign if_instrn     = r_instrn;
  assign if_pc_addrout = r_pc_out;
  assign if_pcp4       = r_pcp4;
  assign if_valid      = r_valid;

`ifdef IF_FETCH_ALIGN_CHK_EN
  logic r_misalign;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_misalign <= 1'b0;
    else     r_misalign <= redirect && (redirect_addr[1:0] != 2'b00);
  end

  assign if_misalign = r_misalign;
`else
  logic w_unused_low_bits;
  assign w_unused_low_bits = ^redirect_addr[1:0];
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch against an instruction-stream reference model.
module tb_if_fetch;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic [31:0] if_instrn;
  logic [31:0] if_pc_addrout;
  logic [31:0] if_pcp4;
  logic        if_valid;
`ifdef IF_FETCH_ALIGN_CHK_EN
  logic        if_misalign;
`endif

  if_fetch #(.RESET_PC(RPC)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .if_instrn     (if_instrn),
    .if_pc_addrout (if_pc_addrout),
    .if_pcp4       (if_pcp4),
    .if_valid      (if_valid)
`ifdef IF_FETCH_ALIGN_CHK_EN
    ,
    .if_misalign   (if_misalign)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } item_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the instruction stream the pipeline must see.
  logic        m_valid;
  item_t       m_out;
  logic [31:0] m_fetch_pc;
  bit          m_stale;
  logic [31:0] m_stale_addr;
  item_t       skq[$];
  bit          m_mis;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid    = 1'b0;
    m_out      = '0;
    m_fetch_pc = RPC;
    m_stale    = 1'b0;
    m_stale_addr = '0;
    skq.delete();
    m_mis      = 1'b0;
  endtask

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_step();
    bit    req_m;
    bit    accept;
    item_t fetched;
    req_m   = (skq.size() == 0);
    accept  = req_m && imem_ack && !m_stale && !redirect;
    fetched = '{instr: mem_word(m_fetch_pc), pc: m_fetch_pc};
    m_mis   = redirect && (redirect_addr[1:0] != 2'b00);
    if (redirect) begin
      m_valid = 1'b0;
      skq.delete();
      if (req_m && !imem_ack) begin
        if (!m_stale) m_stale_addr = m_fetch_pc;
        m_stale = 1'b1;
      end else begin
        m_stale = 1'b0;
      end
      m_fetch_pc = {redirect_addr[31:2], 2'b00};
    end else begin
      if (m_stale && imem_ack) m_stale = 1'b0;
      if (accept) m_fetch_pc = m_fetch_pc + 32'd4;
      if (!stall) begin
        if (skq.size() != 0) begin
          m_out   = skq.pop_front();
          m_valid = 1'b1;
        end else if (accept) begin
          m_out   = fetched;
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end else if (accept) begin
        if (m_valid) skq.push_back(fetched);
        else begin
          m_out   = fetched;
          m_valid = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_outputs();
    bit exp_req;
    exp_req = (skq.size() == 0);
    check32("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req)
      check32("imem_addr", imem_addr, m_stale ? m_stale_addr : m_fetch_pc);
    check32("if_valid", 32'(if_valid), 32'(m_valid));
    if (m_valid) begin
      check32("if_instrn", if_instrn, m_out.instr);
      check32("if_pc_addrout", if_pc_addrout, m_out.pc);
      check32("if_pcp4", if_pcp4, m_out.pc + 32'd4);
    end
`ifdef IF_FETCH_ALIGN_CHK_EN
    check32("if_misalign", 32'(if_misalign), 32'(m_mis));
`endif
  endtask

  // One clock: drive inputs just after a falling edge, compare at the next one.
  task automatic step(input bit st, input bit rd, input logic [31:0] ra, input bit ak);
    stall         = st;
    redirect      = rd;
    redirect_addr = ra;
    imem_ack      = ak && imem_req;
    imem_rdata    = imem_ack ? mem_word(imem_addr) : $urandom();
    model_step();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    stall    = 1'b0;
    redirect = 1'b0;
    redirect_addr = '0;
    #1;
    check32("rst_req", 32'(imem_req), 32'd0);
    check32("rst_valid", 32'(if_valid), 32'd0);
    check32("rst_instrn", if_instrn, 32'd0);
    check32("rst_pc", if_pc_addrout, 32'd0);
    check32("rst_pcp4", if_pcp4, 32'd0);
    for (int i = 0; i < 2; i++) begin
      imem_ack   = 1'b1;
      imem_rdata = $urandom();
      @(negedge clk);
      check32("rst_req_hold", 32'(imem_req), 32'd0);
    end
    imem_ack = 1'b0;
    rst      = 1'b0;
    model_reset();
    #1;
    compare_outputs();
  endtask

  initial begin
    rst = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = '0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_addr = '0;
    @(negedge clk);
    do_reset();
    check32("first_addr", imem_addr, 32'h100);

    // Back-to-back stream from RESET_PC.
    step(0, 0, 0, 1);
    check32("lit_pc0", if_pc_addrout, 32'h100);
    check32("lit_pcp4_0", if_pcp4, 32'h104);
    step(0, 0, 0, 1);
    check32("lit_pc1", if_pc_addrout, 32'h104);
    step(0, 0, 0, 1);
    check32("lit_pc2", if_pc_addrout, 32'h108);
    check32("lit_pcp4_2", if_pcp4, 32'h10C);

    // Stall with a response in flight parks it in the skid.
    step(1, 0, 0, 1);
    check32("lit_hold_req", 32'(imem_req), 32'd0);
    check32("lit_hold_pc", if_pc_addrout, 32'h108);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    check32("lit_frozen_pc", if_pc_addrout, 32'h108);
    step(0, 0, 0, 1);
    check32("lit_skid_pc", if_pc_addrout, 32'h10C);
    check32("lit_skid_addr", imem_addr, 32'h110);

    // Redirect while a request is outstanding.
    step(0, 1, 32'h40, 1);
    check32("lit_redir_addr", imem_addr, 32'h40);
    step(0, 1, 32'h2000, 0);
    check32("lit_disc_addr", imem_addr, 32'h40);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check32("lit_disc_stable", imem_addr, 32'h40);
    step(0, 0, 0, 1);
    check32("lit_disc_drop", 32'(if_valid), 32'd0);
    check32("lit_target_addr", imem_addr, 32'h2000);
    step(0, 0, 0, 1);
    check32("lit_target_pc", if_pc_addrout, 32'h2000);

    // Redirect coinciding with ack and stall.
    step(1, 1, 32'h3000, 1);
    check32("lit_rs_valid", 32'(if_valid), 32'd0);
    check32("lit_rs_addr", imem_addr, 32'h3000);
    step(1, 0, 0, 1);
    check32("lit_bubble_fill", if_pc_addrout, 32'h3000);
    step(1, 0, 0, 1);
    step(1, 1, 32'h3100, 0);
    check32("lit_hold_redir_req", 32'(imem_req), 32'd1);
    check32("lit_hold_redir_addr", imem_addr, 32'h3100);

    // PC wrap.
    step(0, 1, 32'hFFFF_FFFC, 1);
    step(0, 0, 0, 1);
    check32("lit_wrap_pcp4", if_pcp4, 32'h0);
    check32("lit_wrap_addr", imem_addr, 32'h0);
    step(0, 0, 0, 1);
    check32("lit_wrap_pc", if_pc_addrout, 32'h0);

    // Unaligned redirect target.
    step(0, 1, 32'h1003, 1);
    check32("lit_align_addr", imem_addr, 32'h1000);
`ifdef IF_FETCH_ALIGN_CHK_EN
    check32("lit_misalign_hi", 32'(if_misalign), 32'd1);
`endif
    step(0, 0, 0, 0);
`ifdef IF_FETCH_ALIGN_CHK_EN
    check32("lit_misalign_lo", 32'(if_misalign), 32'd0);
`endif

    // Randomized traffic with an occasional mid-stream reset.
    for (int c = 0; c < 4000; c++) begin
      bit          st, rd, ak;
      logic [31:0] ra;
      st = ($urandom % 4) == 0;
      rd = ($urandom % 16) == 0;
      ak = ($urandom % 3) != 0;
      case ($urandom % 4)
        0: ra = $urandom();
        1: ra = 32'hFFFF_FFF0 | 32'($urandom % 16);
        2: ra = 32'($urandom % 256);
        default: ra = $urandom() & 32'hFFFF_FFFC;
      endcase
      if (c == 1500 || c == 3100) do_reset();
      else step(st, rd, ra, ak);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction fetch unit that owns the program counter, issues word requests to instruction memory, and writes the fetched instruction, its PC, and PC+4 into the IF/ID pipeline register. It honours the hazard unit's stall and the EX stage's branch/jump redirect. A one-entry skid buffer absorbs a memory response that returns while the pipeline is stalled.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request. Forced 0 while rst is high.
- imem_addr  out  32  word address; stable while imem_req is high and imem_ack is low.
- imem_ack  in  1  response strobe; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- stall  in  1  hazard unit hold; the IF/ID register must not capture while high.
- redirect  in  1  one-cycle branch/jump taken pulse.
- redirect_addr  in  32  target PC; bits [1:0] are cleared internally.
- if_instrn  out  32  instruction to IF/ID.
- if_pc_addrout  out  32  PC of if_instrn.
- if_pcp4  out  32  if_pc_addrout + 4, mod 2^32.
- if_valid  out  1  outputs hold a real instruction; 0 = bubble.
- if_misalign  out  1  present only with IF_FETCH_ALIGN_CHK_EN.

## Operation
- Registers:
  - pc: next fetch address.
  - disc_addr: held address for a discarded request.
  - skid: data, pc, and valid.
  - state: FETCH, HOLD, or DISCARD.
- Reset values: state=FETCH, pc=RESET_PC, skid empty, if_valid=0, if_instrn=0, if_pc_addrout=0, if_pcp4=0, if_misalign=0.
- Request outputs:
  - imem_req=1 in FETCH and DISCARD, 0 in HOLD.
  - imem_addr=pc in FETCH, disc_addr in DISCARD.
- Memory protocol: a request is never withdrawn or altered before its ack.
- The output register is consumed on each cycle with stall=0. On such a cycle it loads, in priority order:
  - skid contents, if skid is valid;
  - otherwise a FETCH ack: if_instrn=imem_rdata, if_pc_addrout=pc, if_pcp4=pc+4;
  - otherwise a bubble (if_valid=0).
- FETCH, accepted ack: pc <= pc+4.
- FETCH, ack with stall=1 and if_valid=1: the response goes into skid, pc <= pc+4, state becomes HOLD.
- FETCH, ack with stall=1 and if_valid=0: the response loads the output register directly; there is no bubble to protect.
- HOLD: stays in HOLD while stall=1. On stall=0, skid moves to the output, skid is cleared, and state becomes FETCH.
- Redirect has priority over stall and over any ack in the same cycle:
  - if_valid <= 0 and skid is cleared.
  - pc <= {redirect_addr[31:2], 2'b00}.
  - Any ack arriving in the same cycle is dropped.
  - If state is FETCH with no ack that cycle: disc_addr <= current pc, state becomes DISCARD.
  - Otherwise: state becomes FETCH.
- DISCARD: on ack, the data is dropped and state becomes FETCH. A redirect while in DISCARD updates pc only.
- PC arithmetic wraps modulo 2^32; 32'hFFFF_FFFC + 4 = 0.

## Timing
- Fetch-to-output latency: an ack in cycle N (FETCH, stall=0) makes the outputs valid in cycle N+1.
- Throughput: with imem_ack tied high and stall=0, one instruction per cycle, PC incrementing by 4 each cycle.
- First request is issued in the first cycle after rst deasserts, with imem_addr=RESET_PC.
- Redirect in cycle N: if_valid=0 in N+1. The first request to the target is issued in N+1 if state becomes FETCH, or in the cycle after the discarded ack if state becomes DISCARD.
- Skid release: stall falling in cycle M puts the skid instruction on the outputs in M+1, and the new request is issued in M+1.
- Reset asserted mid-request: all state clears immediately; any ack during or after reset for the pre-reset request is ignored.

## Configuration
- IF_FETCH_ALIGN_CHK_EN defined: adds if_misalign. It pulses 1 for one cycle (cycle N+1) when a redirect in cycle N has redirect_addr[1:0] != 0. The target is still word-aligned.
- IF_FETCH_ALIGN_CHK_EN undefined: the port is absent and low address bits are cleared silently.

## Test plan
- Reset with RESET_PC=32'h0000_0100, imem_ack=1, rdata=addr: if_pc_addrout = 0x100, 0x104, 0x108 on consecutive cycles; if_pcp4 = 0x104, 0x108, 0x10C.
- Stall held 3 cycles while an ack arrives: outputs frozen, imem_req=0 in HOLD. Stall drop: skid instruction on outputs next cycle, no instruction lost or duplicated.
- Redirect to 0x2000 while a request to 0x40 is un-acked:
  - imem_addr stays 0x40 until ack;
  - that data never reaches the outputs;
  - next request is to 0x2000.
- Redirect coinciding with ack and stall=1: ack dropped, skid cleared, if_valid=0, next fetch address = target.
- PC at 0xFFFF_FFFC acked: if_pcp4=0, next imem_addr=0.
- With IF_FETCH_ALIGN_CHK_EN, redirect_addr=0x1003: if_misalign pulses 1 for one cycle, next imem_addr=0x1000.
